cbf_hash_counter: RTL and testbench
===================================

Name: cbf_hash_counter

Overview:
- Counting Bloom filter core built from two elements: a deterministic xor-rotate-fold hash (k instances per port) and wrap-around up/down bucket counters.
- Supports a combinational membership lookup, synchronous insert (increment) and remove (decrement) of data items, and status flags.
- Sits as a set-membership tracker, for example outstanding-transaction IDs, inside a bus or cache controller.

Parameters:
- KHashes, 3: number of hash functions.
- HashWidth, 4: hash output width; number of buckets NB = 2**HashWidth.
- HashRounds, 1: xor-rotate rounds per hash.
- InpWidth, 32: data width; must be greater than HashWidth (elaboration error otherwise).
- BucketWidth, 4: width of each bucket counter.
- XorKeys, {32'h2,32'h1,32'h0}: KHashes x InpWidth packed array; entry k is the xor key of hash k.
- RotKeys, {2,1,0}: KHashes x int array; entry k is the left-rotate amount of hash k, taken modulo InpWidth.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- look_data_i  in  InpWidth  data to look up.
- look_valid_o  out  1  look_data_i is (possibly falsely) a member.
- incr_data_i  in  InpWidth  data to insert.
- incr_valid_i  in  1  insert strobe.
- decr_data_i  in  InpWidth  data to remove.
- decr_valid_i  in  1  remove strobe.
- filter_clear_i  in  1  synchronous clear.
- filter_usage_o  out  HashWidth  net number of items held.
- filter_full_o  out  1  a bucket is saturated or overflowing.
- filter_empty_o  out  1  all buckets are zero.
- filter_error_o  out  1  a counter wrapped this cycle.

Behaviour:
- Hash k (purely combinational):
  - y = data.
  - Repeat HashRounds times: y = rotl(y ^ XorKeys[k], RotKeys[k]).
  - h = XOR of all HashWidth-bit slices of y; the top slice is zero-padded.
  - onehot_k = 1 << h.
- Indicator ind = OR of onehot_k over all k. Three independent hash sets are used: look, incr, decr.
- Counter element (one per bucket, plus a usage counter of width HashWidth):
  - Reset sets it to 0.
  - clear has priority and sets it to 0 on the next edge.
  - When en is high, the value goes +1, or -1 if down is high, with modulo wrap.
  - overflow is combinational: en & ~down & value==all-ones, or en & down & value==0.
- Bucket control:
  - down = decr_valid_i ? decr_ind : 0.
  - en, by {incr_valid_i, decr_valid_i}: 00 -> 0; 10 -> incr_ind; 01 -> decr_ind; 11 -> incr_ind ^ decr_ind.
  - With both strobes, a bucket hit by both hashes is unchanged.
- Usage counter: en = incr_valid_i ^ decr_valid_i, down = decr_valid_i. It is unchanged when both strobes are high.
- look_valid_o = ((look_ind & occupied) == look_ind), where occupied[i] = |bucket[i]. Combinational, zero latency; it reflects registered bucket state.
- filter_full_o = OR over buckets of (overflow[i] | &bucket[i]).
- filter_empty_o = AND over buckets of (bucket[i]==0).
- filter_error_o = OR of bucket overflows | usage overflow. Combinational, not sticky.
- Reset and clear values: buckets=0, usage=0, empty=1, full=0, error=0 (with strobes low), look_valid_o=0.
- Reset mid-operation aborts any in-flight update.
- Insert or remove takes effect on the next rising edge after the strobe.
- Removing data never inserted corrupts state; no protection is provided.

Test Plan:
- Reset with all inputs 0 -> usage=0, empty=1, full=0, error=0, look_valid_o=0 for look_data=0.
- Default keys: data 0 hashes to buckets {0,2,8}; data 1 hashes to {1,0,12}.
  - Insert 0 for one cycle -> usage=1, empty=0.
  - Look 0 -> 1; look 1 -> 0 (buckets 1 and 12 are empty).
- Insert 0, then insert 1 -> bucket0=2, usage=2, look 1 -> 1. Remove 0 -> usage=1, look 0 -> 0 (buckets 2 and 8 are now 0), look 1 -> 1.
- Same cycle: incr=0, decr=1 after prior insert of 1 -> bucket0 unchanged, buckets 2,8 +1, buckets 1,12 -1, usage unchanged.
- Insert 0 fifteen times -> bucket0=15, full=1.
  - 16th insert: error=1 during that cycle; after the edge, bucket0=0 and usage=0 (wrap).
- filter_clear_i with incr_valid_i high -> all counters 0, empty=1; the clear wins.

Source files
------------

// File: rtl/cbf_hash_counter.sv
`default_nettype none
// ============================================================================
//  Module      : cbf_hash_counter
//  Description : Counting Bloom filter with xor-rotate-fold hashing and
//                wrap-around up/down bucket counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module cbf_hash_counter #(
    parameter int                                   K_HASHES     = 3,
    parameter int                                   HASH_WIDTH   = 4,
    parameter int                                   HASH_ROUNDS  = 1,
    parameter int                                   INP_WIDTH    = 32,
    parameter int                                   BUCKET_WIDTH = 4,
    parameter logic [K_HASHES-1:0][INP_WIDTH-1:0]   XOR_KEYS     = {32'h2, 32'h1, 32'h0},
    parameter int unsigned                          ROT_KEYS [K_HASHES-1:0] = '{2, 1, 0}
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [INP_WIDTH-1:0]  look_data_i,
    output logic                  look_valid_o,
    input  logic [INP_WIDTH-1:0]  incr_data_i,
    input  logic                  incr_valid_i,
    input  logic [INP_WIDTH-1:0]  decr_data_i,
    input  logic                  decr_valid_i,
    input  logic                  filter_clear_i,
    output logic [HASH_WIDTH-1:0] filter_usage_o,
    output logic                  filter_full_o,
    output logic                  filter_empty_o,
    output logic                  filter_error_o
);

    localparam int c_nb     = 2 ** HASH_WIDTH;
    localparam int c_slices = (INP_WIDTH + HASH_WIDTH - 1) / HASH_WIDTH;

    localparam logic [BUCKET_WIDTH-1:0] c_bkt_one = BUCKET_WIDTH'(1);
    localparam logic [HASH_WIDTH-1:0]   c_use_one = HASH_WIDTH'(1);

    if (INP_WIDTH <= HASH_WIDTH) begin : g_bad_width
        $error("cbf_hash_counter: INP_WIDTH must exceed HASH_WIDTH");
    end

    function automatic logic [INP_WIDTH-1:0] f_rotl(input logic [INP_WIDTH-1:0] x,
                                                    input int unsigned          r);
        int unsigned s;
        s = r % $unsigned(INP_WIDTH);
        if (s == 0) return x;
        return (x << s) | (x >> ($unsigned(INP_WIDTH) - s));
    endfunction

    // OR of the one-hot bucket selects produced by every hash function
    function automatic logic [c_nb-1:0] f_ind(input logic [INP_WIDTH-1:0] data);
        logic [c_nb-1:0]                  ind;
        logic [INP_WIDTH-1:0]             y;
        logic [c_slices*HASH_WIDTH-1:0]   padded;
        logic [HASH_WIDTH-1:0]            h;
        ind = '0;
        for (int k = 0; k < K_HASHES; k++) begin
            y = data;
            for (int r = 0; r < HASH_ROUNDS; r++) begin
                y = f_rotl(y ^ XOR_KEYS[k], ROT_KEYS[k]);
            end
            padded = (c_slices*HASH_WIDTH)'(y);
            h = '0;
            for (int s = 0; s < c_slices; s++) begin
                h = h ^ padded[s*HASH_WIDTH +: HASH_WIDTH];
            end
            ind[h] = 1'b1;
        end
        return ind;
    endfunction

    logic [c_nb-1:0][BUCKET_WIDTH-1:0] r_bucket;
    logic [c_nb-1:0][BUCKET_WIDTH-1:0] w_bkt_next;
    logic [HASH_WIDTH-1:0]             r_usage;

    logic [c_nb-1:0] w_look_ind;
    logic [c_nb-1:0] w_incr_ind;
    logic [c_nb-1:0] w_decr_ind;
    logic [c_nb-1:0] w_bkt_en;
    logic [c_nb-1:0] w_bkt_down;
    logic [c_nb-1:0] w_bkt_ovf;
    logic [c_nb-1:0] w_bkt_sat;
    logic [c_nb-1:0] w_bkt_zero;
    logic [c_nb-1:0] w_occupied;
    logic            w_use_en;
    logic            w_use_ovf;

    assign w_look_ind = f_ind(look_data_i);
    assign w_incr_ind = f_ind(incr_data_i);
    assign w_decr_ind = f_ind(decr_data_i);

    // A bucket hit by both insert and remove in one cycle nets to no change
    always_comb begin
        w_bkt_en = '0;
        case ({incr_valid_i, decr_valid_i})
            2'b10:   w_bkt_en = w_incr_ind;
            2'b01:   w_bkt_en = w_decr_ind;
            2'b11:   w_bkt_en = w_incr_ind ^ w_decr_ind;
            default: w_bkt_en = '0;
        endcase
    end

    assign w_bkt_down = decr_valid_i ? w_decr_ind : '0;

    for (genvar i = 0; i < c_nb; i++) begin : g_bucket
        assign w_bkt_sat[i]  = &r_bucket[i];
        assign w_bkt_zero[i] = (r_bucket[i] == '0);
        assign w_occupied[i] = ~w_bkt_zero[i];
        assign w_bkt_ovf[i]  = w_bkt_en[i] & (w_bkt_down[i] ? w_bkt_zero[i] : w_bkt_sat[i]);
        assign w_bkt_next[i] = w_bkt_down[i] ? (r_bucket[i] - c_bkt_one)
                                             : (r_bucket[i] + c_bkt_one);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bucket <= '0;
        end else if (filter_clear_i) begin
            r_bucket <= '0;
        end else begin
            for (int i = 0; i < c_nb; i++) begin
                if (w_bkt_en[i]) r_bucket[i] <= w_bkt_next[i];
            end
        end
    end

    assign w_use_en  = incr_valid_i ^ decr_valid_i;
    assign w_use_ovf = w_use_en & (decr_valid_i ? (r_usage == '0) : (&r_usage));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_usage <= '0;
        end else if (filter_clear_i) begin
            r_usage <= '0;
        end else if (w_use_en) begin
            r_usage <= decr_valid_i ? (r_usage - c_use_one) : (r_usage + c_use_one);
        end
    end

    assign look_valid_o   = ((w_look_ind & w_occupied) == w_look_ind);
    assign filter_usage_o = r_usage;
    assign filter_full_o  = |(w_bkt_ovf | w_bkt_sat);
    assign filter_empty_o = &w_bkt_zero;
    assign filter_error_o = (|w_bkt_ovf) | w_use_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cbf_hash_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cbf_hash_counter
//  Description : Directed self-checking bench for cbf_hash_counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cbf_hash_counter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] look_data_i = '0;
    logic        look_valid_o;
    logic [31:0] incr_data_i = '0;
    logic        incr_valid_i = 1'b0;
    logic [31:0] decr_data_i = '0;
    logic        decr_valid_i = 1'b0;
    logic        filter_clear_i = 1'b0;
    logic [3:0]  filter_usage_o;
    logic        filter_full_o;
    logic        filter_empty_o;
    logic        filter_error_o;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk_i = ~clk_i;

    cbf_hash_counter dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .look_data_i    (look_data_i),
        .look_valid_o   (look_valid_o),
        .incr_data_i    (incr_data_i),
        .incr_valid_i   (incr_valid_i),
        .decr_data_i    (decr_data_i),
        .decr_valid_i   (decr_valid_i),
        .filter_clear_i (filter_clear_i),
        .filter_usage_o (filter_usage_o),
        .filter_full_o  (filter_full_o),
        .filter_empty_o (filter_empty_o),
        .filter_error_o (filter_error_o)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic look(input logic [31:0] d, input string tag, input logic exp);
        look_data_i = d;
        #1;
        check(tag, {31'd0, look_valid_o}, {31'd0, exp});
    endtask

    initial begin
        // Reset
        repeat (2) tick();
        rst_i = 1'b0;
        #1;
        check("rst_usage", {28'd0, filter_usage_o}, 32'd0);
        check("rst_empty", {31'd0, filter_empty_o}, 32'd1);
        check("rst_full",  {31'd0, filter_full_o},  32'd0);
        check("rst_error", {31'd0, filter_error_o}, 32'd0);
        look(32'd0, "rst_look0", 1'b0);

        // Insert 0 -> buckets {0,2,8}
        incr_data_i = 32'd0; incr_valid_i = 1'b1;
        tick();
        incr_valid_i = 1'b0;
        #1;
        check("ins0_usage", {28'd0, filter_usage_o}, 32'd1);
        check("ins0_empty", {31'd0, filter_empty_o}, 32'd0);
        look(32'd0, "ins0_look0", 1'b1);
        look(32'd1, "ins0_look1", 1'b0);

        // Insert 1 -> buckets {1,0,12}
        incr_data_i = 32'd1; incr_valid_i = 1'b1;
        tick();
        incr_valid_i = 1'b0;
        #1;
        check("ins1_usage", {28'd0, filter_usage_o}, 32'd2);
        look(32'd1, "ins1_look1", 1'b1);

        // Remove 0 -> b0=1, b2=b8=0
        decr_data_i = 32'd0; decr_valid_i = 1'b1;
        tick();
        decr_valid_i = 1'b0;
        #1;
        check("rem0_usage", {28'd0, filter_usage_o}, 32'd1);
        look(32'd0, "rem0_look0", 1'b0);
        look(32'd1, "rem0_look1", 1'b1);

        // Simultaneous insert 0 / remove 1: b0 kept, b2,b8 up, b1,b12 down
        incr_data_i = 32'd0; incr_valid_i = 1'b1;
        decr_data_i = 32'd1; decr_valid_i = 1'b1;
        #1;
        check("both_error", {31'd0, filter_error_o}, 32'd0);
        tick();
        incr_valid_i = 1'b0; decr_valid_i = 1'b0;
        #1;
        check("both_usage", {28'd0, filter_usage_o}, 32'd1);
        look(32'd0, "both_look0", 1'b1);
        look(32'd1, "both_look1", 1'b0);

        // Clear wins over a concurrent insert
        filter_clear_i = 1'b1; incr_data_i = 32'd0; incr_valid_i = 1'b1;
        tick();
        filter_clear_i = 1'b0; incr_valid_i = 1'b0;
        #1;
        check("clr_usage", {28'd0, filter_usage_o}, 32'd0);
        check("clr_empty", {31'd0, filter_empty_o}, 32'd1);
        check("clr_full",  {31'd0, filter_full_o},  32'd0);
        look(32'd0, "clr_look0", 1'b0);

        // Saturate buckets {0,2,8} with fifteen inserts of 0
        incr_data_i = 32'd0; incr_valid_i = 1'b1;
        repeat (14) tick();
        check("sat14_full", {31'd0, filter_full_o}, 32'd0);
        tick();
        incr_valid_i = 1'b0;
        #1;
        check("sat_usage", {28'd0, filter_usage_o}, 32'd15);
        check("sat_full",  {31'd0, filter_full_o},  32'd1);
        check("sat_error", {31'd0, filter_error_o}, 32'd0);

        // 16th insert wraps every touched counter
        incr_valid_i = 1'b1;
        #1;
        check("wrap_error_now", {31'd0, filter_error_o}, 32'd1);
        tick();
        incr_valid_i = 1'b0;
        #1;
        check("wrap_usage", {28'd0, filter_usage_o}, 32'd0);
        check("wrap_empty", {31'd0, filter_empty_o}, 32'd1);
        check("wrap_full",  {31'd0, filter_full_o},  32'd0);
        check("wrap_error", {31'd0, filter_error_o}, 32'd0);

        // Removing from an empty filter underflows
        decr_data_i = 32'd0; decr_valid_i = 1'b1;
        #1;
        check("under_error_now", {31'd0, filter_error_o}, 32'd1);
        tick();
        decr_valid_i = 1'b0;
        #1;
        check("under_usage", {28'd0, filter_usage_o}, 32'd15);
        check("under_full",  {31'd0, filter_full_o},  32'd1);

        // Asynchronous reset away from the clock edge
        #2;
        rst_i = 1'b1;
        #1;
        check("arst_usage", {28'd0, filter_usage_o}, 32'd0);
        check("arst_empty", {31'd0, filter_empty_o}, 32'd1);
        rst_i = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
